// File: rtl/lift_pkg.sv
// Shared definitions for the lift subsystem: hall-call request codes,
// direction encodings driven by the controller, and code validation.
package lift_pkg;

  // Hall-call request codes (floor + direction)
  localparam logic [2:0] REQ_NONE = 3'b000;
  localparam logic [2:0] REQ_1U   = 3'b001;
  localparam logic [2:0] REQ_2U   = 3'b010;
  localparam logic [2:0] REQ_3U   = 3'b011;
  localparam logic [2:0] REQ_4D   = 3'b100;
  localparam logic [2:0] REQ_RSVD = 3'b101;
  localparam logic [2:0] REQ_2D   = 3'b110;
  localparam logic [2:0] REQ_3D   = 3'b111;

  // Direction output encodings used by the controller FSM
  typedef enum logic [1:0] {
    DIR_UP   = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_STAY = 2'b10
  } dir_t;

  // A code is serviceable unless it is the empty marker or the unused slot
  function automatic logic is_valid_code(input logic [2:0] code);
    return (code != REQ_NONE) && (code != REQ_RSVD);
  endfunction

endpackage

// File: rtl/lift_req_fifo.sv
// Circular-buffer core for 3-bit request codes. Head and empty flag are
// registered and precomputed so the consumer sees them right after the edge.
// Pushes while full and pops while empty are ignored.
module lift_req_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [2:0]       wdata,
  input  logic             pop,
  output logic [2:0]       head,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count_nxt;
  logic [2:0]       head_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next occupancy, read pointer, and the code that will sit at the head
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    head_nxt   = 3'b000;
    if (pop_ok) rd_ptr_nxt = rd_ptr + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    // The incoming code becomes the head only when it is the sole entry left
    if (count_nxt != '0)
      head_nxt = (push_ok && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
  end

  // Pointer, occupancy and registered head/empty state
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= 3'b000;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
      empty  <= (count_nxt == '0);
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are live.
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lift_req_queue.sv
// Hall-call request queue in front of the lift controller. Rejects invalid
// codes and codes already waiting, keeps arrival order, and pops the head
// when the controller reports it done.
module lift_req_queue
  import lift_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [2:0]       req_code,
  output logic             req_ready,
  input  logic             done,
  output logic [2:0]       din,
  output logic             q_empty,
  output logic             drop_bad,
  output logic             drop_dup,
  output logic [PTR_W:0]   count
);

  logic [7:0] pending;
  logic [7:0] pending_nxt;
  logic       full;
  logic       hs;
  logic       pop;
  logic       code_bad;
  logic       code_dup;
  logic       store;

  assign req_ready = !full;
  assign hs        = req_valid && req_ready;
  assign pop       = done && !q_empty;
  assign code_bad  = !is_valid_code(req_code);
  // A code leaving the head this cycle is no longer a duplicate
  assign code_dup  = pending[req_code] && !(pop && (din == req_code));
  assign store     = hs && !code_bad && !code_dup;

  lift_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (store),
    .wdata (req_code),
    .pop   (pop),
    .head  (din),
    .empty (q_empty),
    .full  (full),
    .count (count)
  );

  // Pending set: clear the popped head first, then mark the stored code
  always_comb begin
    pending_nxt = pending;
    if (pop)   pending_nxt[din]      = 1'b0;
    if (store) pending_nxt[req_code] = 1'b1;
  end

  // Pending bits and one-cycle drop pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      drop_bad <= 1'b0;
      drop_dup <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      drop_bad <= hs && code_bad;
      drop_dup <= hs && !code_bad && code_dup;
    end
  end

endmodule

// File: tb/tb_lift_req_queue.sv
// Directed bench for lift_req_queue with a reference queue model acting as
// scoreboard: codes are pushed when the model accepts them and popped and
// compared against din when the controller pulse retires the head.
module tb_lift_req_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [2:0]       req_code;
  logic             req_ready;
  logic             done;
  logic [2:0]       din;
  logic             q_empty;
  logic             drop_bad;
  logic             drop_dup;
  logic [PTR_W:0]   count;

  int checks = 0;
  int errors = 0;

  logic [2:0] mq[$];
  logic [7:0] mpend;

  lift_req_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .done      (done),
    .din       (din),
    .q_empty   (q_empty),
    .drop_bad  (drop_bad),
    .drop_dup  (drop_dup),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every registered output against the model state
  task automatic check_state(input string tag, input logic e_bad, input logic e_dup);
    check({tag, ":count"},    32'(count),    32'(mq.size()));
    check({tag, ":q_empty"},  32'(q_empty),  32'(mq.size() == 0));
    check({tag, ":din"},      32'(din),      (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check({tag, ":drop_bad"}, 32'(drop_bad), 32'(e_bad));
    check({tag, ":drop_dup"}, 32'(drop_dup), 32'(e_dup));
  endtask

  // One clock of stimulus; called at #1 after a rising edge
  task automatic step(input logic v, input logic [2:0] c, input logic d, input string tag);
    logic m_full, m_hs, m_pop, e_bad, e_dup;
    req_valid = v;
    req_code  = c;
    done      = d;
    m_full = (mq.size() == DEPTH);
    m_pop  = d && (mq.size() != 0);
    m_hs   = v && !m_full;
    check({tag, ":req_ready"}, 32'(req_ready), 32'(!m_full));
    e_bad = m_hs && (c == 3'b000 || c == 3'b101);
    e_dup = m_hs && !e_bad && mpend[c] && !(m_pop && mq[0] == c);
    if (m_pop) begin
      check({tag, ":pop_head"}, 32'(din), 32'(mq[0]));
      mpend[mq[0]] = 1'b0;
      void'(mq.pop_front());
    end
    if (m_hs && !e_bad && !e_dup) begin
      mq.push_back(c);
      mpend[c] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state(tag, e_bad, e_dup);
    req_valid = 1'b0;
    req_code  = 3'b000;
    done      = 1'b0;
  endtask

  // Reset with an optional push handshake presented in the same cycle
  task automatic do_reset(input logic v, input logic [2:0] c, input string tag);
    rst       = 1'b1;
    req_valid = v;
    req_code  = c;
    done      = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_code  = 3'b000;
    mq.delete();
    mpend = '0;
    check_state(tag, 1'b0, 1'b0);
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_code = 3'b000; done = 1'b0;
    mpend = '0;
    @(posedge clk);
    do_reset(1'b0, 3'b000, "reset");

    // Basic ordering and first-push latency
    step(1'b1, 3'b001, 1'b0, "push1");
    step(1'b1, 3'b011, 1'b0, "push3");
    step(1'b1, 3'b110, 1'b0, "push2d");

    // Duplicate and invalid codes
    step(1'b1, 3'b001, 1'b0, "dup1");
    step(1'b0, 3'b000, 1'b0, "dup_gap");
    step(1'b1, 3'b000, 1'b0, "bad000");
    step(1'b1, 3'b101, 1'b0, "bad101");

    // Drain, then done on empty queue
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 1'b1, "drain");
    step(1'b0, 3'b000, 1'b1, "done_empty");

    // Fill to full, hold 110 until a done frees a slot
    step(1'b1, 3'b001, 1'b0, "fill");
    step(1'b1, 3'b010, 1'b0, "fill");
    step(1'b1, 3'b011, 1'b0, "fill");
    step(1'b1, 3'b100, 1'b0, "fill");
    step(1'b1, 3'b110, 1'b0, "hold_full");
    step(1'b1, 3'b110, 1'b0, "hold_full");
    step(1'b1, 3'b110, 1'b1, "hold_pop");
    step(1'b1, 3'b110, 1'b0, "hold_accept");

    // Hold done three cycles with four entries, then empty
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 1'b1, "done_hold");
    step(1'b0, 3'b000, 1'b1, "done_last");

    // Pointer wrap over refills
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 3'b111, 1'b0, "refill");
      step(1'b1, 3'b100, 1'b0, "refill");
      step(1'b1, 3'b010, 1'b0, "refill");
      step(1'b1, 3'b001, 1'b0, "refill");
      for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b1, "redrain");
    end

    // Pop and re-push the same code in one cycle
    step(1'b1, 3'b010, 1'b0, "same_push");
    step(1'b1, 3'b010, 1'b1, "same_swap");
    step(1'b1, 3'b010, 1'b0, "same_pending");
    step(1'b0, 3'b000, 1'b1, "same_pop");

    // Reset mid-handshake with three entries
    step(1'b1, 3'b001, 1'b0, "pre_rst");
    step(1'b1, 3'b011, 1'b0, "pre_rst");
    step(1'b1, 3'b100, 1'b0, "pre_rst");
    do_reset(1'b1, 3'b010, "mid_reset");
    step(1'b1, 3'b001, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
